// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the fetch/load-store AHB-Lite bus arbiter.
package mem_bus_arbiter_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_t;

endpackage

// File: rtl/mem_bus_arbiter_select.sv
// Requester selection: load/store wins unless fetch has waited STARVE_MAX ls grants.
module mem_arb_select #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic ls_req,
    input  logic if_gnt,
    input  logic ls_gnt,
    output logic pick_valid,
    output logic pick_if
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (ls_gnt && if_req && (starve_cnt != MAX)) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

    always_comb begin
        pick_valid = if_req | ls_req;
        pick_if    = if_req && (!ls_req || (starve_cnt == MAX));
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and load/store onto one AHB-Lite master port.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int COLS       = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [COLS-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [COLS-1:0] ls_addr,
    input  logic [COLS-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [COLS-1:0] rdata,
    output logic [COLS-1:0] HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [COLS-1:0] HWDATA,
    input  logic [COLS-1:0] HRDATA,
    input  logic            HREADY
);

    state_t          state;
    owner_t          owner;
    logic            lat_we;
    logic [COLS-1:0] lat_wdata;
    logic            pick_valid;
    logic            pick_if;

    mem_arb_select #(
        .STARVE_MAX(STARVE_MAX)
    ) u_select (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .ls_req    (ls_req),
        .if_gnt    (if_gnt),
        .ls_gnt    (ls_gnt),
        .pick_valid(pick_valid),
        .pick_if   (pick_if)
    );

    // Grant must coincide with the accepted address phase, so it follows HREADY directly.
    assign if_gnt = (state == ST_ADDR) && HREADY && (owner == OWN_IF);
    assign ls_gnt = (state == ST_ADDR) && HREADY && (owner == OWN_LS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            HADDR     <= '0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            rdata     <= '0;
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_if ? OWN_IF : OWN_LS;
                        HADDR     <= pick_if ? if_addr : ls_addr;
                        lat_we    <= !pick_if && ls_we;
                        lat_wdata <= pick_if ? '0 : ls_wdata;
                        HWRITE    <= !pick_if && ls_we;
                        HTRANS    <= HTRANS_NONSEQ;
                        state     <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        HWRITE <= 1'b0;
                        if (lat_we) begin
                            HWDATA <= lat_wdata;
                        end
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (!lat_we) begin
                            rdata <= HRDATA;
                        end
                        if (owner == OWN_IF) begin
                            if_rvalid <= 1'b1;
                        end else begin
                            ls_rvalid <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic        if_rvalid;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] rdata;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;

    int checks = 0;
    int fails  = 0;

    mem_bus_arbiter #(
        .COLS      (32),
        .STARVE_MAX(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .rdata    (rdata),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY)
    );

    always #5 clk = ~clk;

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b00) begin fails++; $display("FAIL reset_htrans: got %b expected 00", HTRANS); end
        checks++;
        if ({HADDR, HWDATA, rdata} !== 96'h0) begin fails++; $display("FAIL reset_buses: got HADDR=%h HWDATA=%h rdata=%h expected 0", HADDR, HWDATA, rdata); end
        checks++;
        if ({HWRITE, if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 5'b0) begin fails++; $display("FAIL reset_pulses: got %b expected 00000", {HWRITE, if_gnt, ls_gnt, if_rvalid, ls_rvalid}); end
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single_load;
        // cycle 1
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; HREADY = 1'b1; HRDATA = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (ls_gnt !== 1'b0 || HTRANS !== 2'b00) begin fails++; $display("FAIL load_c1: got gnt=%b htrans=%b expected 0 00", ls_gnt, HTRANS); end
        // cycle 2
        next_cycle();
        @(negedge clk);
        checks++;
        if (HADDR !== 32'h100 || HTRANS !== 2'b10 || HWRITE !== 1'b0) begin fails++; $display("FAIL load_addr: got %h %b %b expected 00000100 10 0", HADDR, HTRANS, HWRITE); end
        checks++;
        if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin fails++; $display("FAIL load_gnt: got ls=%b if=%b expected 1 0", ls_gnt, if_gnt); end
        // cycle 3
        next_cycle();
        ls_req = 1'b0;
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b00 || ls_rvalid !== 1'b0) begin fails++; $display("FAIL load_data: got htrans=%b rvalid=%b expected 00 0", HTRANS, ls_rvalid); end
        // cycle 4
        next_cycle();
        @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin fails++; $display("FAIL load_rvalid: got ls=%b if=%b expected 1 0", ls_rvalid, if_rvalid); end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata: got %h expected deadbeef", rdata); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b0) begin fails++; $display("FAIL load_pulse_width: got %b expected 0", ls_rvalid); end
    endtask

    task automatic test_store_wait;
        next_cycle();
        // cycle 1
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h12345678;
        HREADY = 1'b1; HRDATA = 32'hCAFEF00D;
        // cycle 2
        next_cycle();
        @(negedge clk);
        checks++;
        if (HADDR !== 32'h200 || HTRANS !== 2'b10 || HWRITE !== 1'b1 || ls_gnt !== 1'b1) begin fails++; $display("FAIL store_addr: got %h %b %b gnt=%b expected 00000200 10 1 1", HADDR, HTRANS, HWRITE, ls_gnt); end
        // cycles 3..5: two wait states then ready
        for (int c = 3; c <= 5; c++) begin
            next_cycle();
            ls_req = 1'b0;
            HREADY = (c == 5);
            @(negedge clk);
            checks++;
            if (HWDATA !== 32'h12345678 || HTRANS !== 2'b00 || ls_rvalid !== 1'b0 || ls_gnt !== 1'b0) begin fails++; $display("FAIL store_data_c%0d: got %h %b rv=%b gnt=%b expected 12345678 00 0 0", c, HWDATA, HTRANS, ls_rvalid, ls_gnt); end
        end
        // cycle 6
        next_cycle();
        @(negedge clk);
        checks++;
        if (ls_rvalid !== 1'b1) begin fails++; $display("FAIL store_rvalid: got %b expected 1", ls_rvalid); end
        checks++;
        if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL store_rdata_kept: got %h expected deadbeef", rdata); end
        ls_we = 1'b0;
    endtask

    task automatic test_simultaneous;
        int ls_g = 0, if_g = 0, both = 0, first = 0, ls_rv = 0, if_rv = 0;
        logic g_ls, g_if;
        next_cycle();
        if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h300; ls_addr = 32'h400; ls_we = 1'b0;
        HREADY = 1'b1; HRDATA = 32'h11111111;
        for (int c = 0; c < 20 && (ls_rv == 0 || if_rv == 0); c++) begin
            @(negedge clk);
            g_ls = ls_gnt;
            g_if = if_gnt;
            if (g_ls && g_if) both++;
            if (g_ls) begin ls_g++; if (if_g == 0 && first == 0) first = 1; end
            if (g_if) begin if_g++; if (ls_g == 0 && first == 0) first = 2; end
            if (ls_rvalid && if_rvalid) both++;
            if (ls_rvalid) begin
                ls_rv++;
                checks++;
                if (rdata !== 32'h11111111) begin fails++; $display("FAIL simul_ls_rdata: got %h expected 11111111", rdata); end
            end
            if (if_rvalid) begin
                if_rv++;
                checks++;
                if (rdata !== 32'h22222222) begin fails++; $display("FAIL simul_if_rdata: got %h expected 22222222", rdata); end
            end
            next_cycle();
            if (g_ls) ls_req = 1'b0;
            if (g_if) begin if_req = 1'b0; HRDATA = 32'h22222222; end
        end
        checks++;
        if (first !== 1) begin fails++; $display("FAIL simul_order: got first=%0d expected 1 (ls)", first); end
        checks++;
        if (ls_g !== 1 || if_g !== 1 || both !== 0) begin fails++; $display("FAIL simul_gnt_count: got ls=%0d if=%0d overlap=%0d expected 1 1 0", ls_g, if_g, both); end
        checks++;
        if (ls_rv !== 1 || if_rv !== 1) begin fails++; $display("FAIL simul_complete: got ls_rv=%0d if_rv=%0d expected 1 1 (timeout)", ls_rv, if_rv); end
    endtask

    task automatic test_starvation;
        int n_ls = 0, got_if = 0, ls_before = -1, both = 0;
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = 32'h700; ls_addr = 32'h800;
        HREADY = 1'b1;
        for (int c = 0; c < 40 && got_if == 0; c++) begin
            @(negedge clk);
            if (ls_gnt && if_gnt) both++;
            if (if_gnt) begin got_if = 1; ls_before = n_ls; end
            if (ls_gnt) n_ls++;
            next_cycle();
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        checks++;
        if (got_if !== 1) begin fails++; $display("FAIL starve_timeout: got if_gnt count %0d expected 1", got_if); end
        checks++;
        if (ls_before !== 3 || both !== 0) begin fails++; $display("FAIL starve_count: got %0d ls grants overlap=%0d expected 3 0", ls_before, both); end
        for (int c = 0; c < 4; c++) next_cycle();
    endtask

    task automatic test_reset_mid_data;
        // cycle 1
        if_req = 1'b1; if_addr = 32'h500; HREADY = 1'b1; HRDATA = 32'h99999999;
        // cycle 2
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) begin fails++; $display("FAIL rstmid_gnt: got %b expected 1", if_gnt); end
        // cycle 3, 4: stalled data phase, reset in cycle 4
        next_cycle();
        if_req = 1'b0; HREADY = 1'b0;
        next_cycle();
        rst = 1'b1;
        // cycle 5
        next_cycle();
        rst = 1'b0; HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b00 || {if_gnt, ls_gnt, if_rvalid, ls_rvalid} !== 4'b0) begin fails++; $display("FAIL rstmid_idle: got htrans=%b pulses=%b expected 00 0000", HTRANS, {if_gnt, ls_gnt, if_rvalid, ls_rvalid}); end
        checks++;
        if (rdata !== 32'h0 || HADDR !== 32'h0) begin fails++; $display("FAIL rstmid_clear: got rdata=%h HADDR=%h expected 0 0", rdata, HADDR); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_no_rvalid: got %b expected 0", if_rvalid); end
        // re-request with one address-phase wait state
        next_cycle();
        if_req = 1'b1; if_addr = 32'h600; HRDATA = 32'h5A5A5A5A;
        next_cycle();
        HREADY = 1'b0;
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h600 || if_gnt !== 1'b0) begin fails++; $display("FAIL refetch_addr_wait: got %b %h gnt=%b expected 10 00000600 0", HTRANS, HADDR, if_gnt); end
        next_cycle();
        HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h600 || if_gnt !== 1'b1) begin fails++; $display("FAIL refetch_gnt: got %b %h gnt=%b expected 10 00000600 1", HTRANS, HADDR, if_gnt); end
        next_cycle();
        if_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b1 || rdata !== 32'h5A5A5A5A) begin fails++; $display("FAIL refetch_done: got rv=%b rdata=%h expected 1 5a5a5a5a", if_rvalid, rdata); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_store_wait();
        test_simultaneous();
        test_starvation();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL expose parameter COLS, default 32, which sets the address and data width.
REQ-002 The block SHALL expose parameter STARVE_MAX, default 3, which is the maximum number of consecutive load/store grants while a fetch is waiting.
REQ-003 Port clk, input, 1: the single clock.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port if_req, input, 1: instruction-fetch request; held until if_gnt.
REQ-006 Port if_addr, input, COLS: fetch address.
REQ-007 Port if_gnt, output, 1: one-cycle pulse when the fetch address phase is accepted.
REQ-008 Port if_rvalid, output, 1: one-cycle pulse when fetch data is valid on rdata.
REQ-009 Port ls_req, input, 1: load/store request from the register-file datapath; held until ls_gnt.
REQ-010 Port ls_we, input, 1: 1 selects a store, 0 selects a load.
REQ-011 Port ls_addr, input, COLS: load/store address (addr2Mem).
REQ-012 Port ls_wdata, input, COLS: store data (data2Mem).
REQ-013 Port ls_gnt, output, 1: one-cycle pulse when the load/store address phase is accepted.
REQ-014 Port ls_rvalid, output, 1: one-cycle pulse on load data valid or store completion.
REQ-015 Port rdata, output, COLS: registered read data, shared by both requesters.
REQ-016 Port HADDR, output, COLS: AHB-Lite address.
REQ-017 Port HTRANS, output, 2: AHB-Lite transfer type, IDLE or NONSEQ only.
REQ-018 Port HWRITE, output, 1: AHB-Lite write strobe.
REQ-019 Port HWDATA, output, COLS: AHB-Lite write data.
REQ-020 Port HRDATA, input, COLS: AHB-Lite read data.
REQ-021 Port HREADY, input, 1: AHB-Lite ready; low inserts wait states.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-023 In IDLE with any request present, the block SHALL latch the winner's addr, we and wdata, record the owner, and enter ADDR on the next cycle.
REQ-024 Arbitration SHALL give ls priority, except that when the starvation counter equals STARVE_MAX and if_req is high, if SHALL win.
REQ-025 The starvation counter SHALL increment on an ls grant while if_req is high, clear on an if grant, and saturate at STARVE_MAX.
REQ-026 In ADDR, the block SHALL drive HTRANS=NONSEQ, HADDR from the latch and HWRITE from the latched we.
REQ-027 The ADDR state SHALL hold all of its outputs while HREADY=0.
REQ-028 On ADDR with HREADY=1, the block SHALL pulse the owner's gnt in that same cycle and enter DATA.
REQ-029 In DATA, the block SHALL drive HTRANS=IDLE and drive HWDATA from the latch whenever the transfer is a write.
REQ-030 The DATA state SHALL wait while HREADY=0.
REQ-031 On DATA with HREADY=1, the block SHALL register HRDATA into rdata (loads and fetches only), pulse the owner's rvalid on the next cycle, and return to IDLE.
REQ-032 Total latency from req to rvalid SHALL be 4 cycles with zero wait states, plus one cycle per HREADY=0 cycle.
REQ-033 Requests arriving outside IDLE SHALL be ignored until the FSM returns to IDLE; no request SHALL ever be dropped while it is held.
REQ-034 When both requests rise in the same cycle, the block SHALL apply REQ-024, and the loser SHALL remain pending.
REQ-035 rdata SHALL hold its value until the next read completion; a store SHALL NOT update rdata.
REQ-036 HTRANS SHALL be IDLE in every state other than ADDR.
REQ-037 At most one gnt and at most one rvalid SHALL be high in any cycle.

Reset
REQ-038 While rst=1 at a clk edge, the block SHALL set state=IDLE, HTRANS=IDLE, HWRITE=0, and set HADDR, HWDATA and rdata to 0.
REQ-039 While rst=1 at a clk edge, the block SHALL set all gnt and rvalid outputs to 0, clear the starvation counter, and clear the owner.
REQ-040 Reset asserted in ADDR or DATA SHALL abandon the transfer with no gnt or rvalid pulse; requesters re-request after reset.

Structure
REQ-041 The shared processor package SHALL hold the HTRANS encodings (IDLE=2'b00, NONSEQ=2'b10), the FSM state enum and the owner enum (OWN_IF, OWN_LS).
REQ-042 The priority/starvation selection SHALL be implemented as one sub-module, mem_arb_select, and all other logic SHALL stay in mem_bus_arbiter.

Verification
REQ-043 The bench SHALL cover a single load: ls_req with ls_addr=0x100, HRDATA=0xDEADBEEF, HREADY=1 -> HADDR=0x100 with NONSEQ in cycle 2, ls_gnt in cycle 2, ls_rvalid with rdata=0xDEADBEEF in cycle 4.
REQ-044 The bench SHALL cover a store with waits: ls_we=1, addr 0x200, wdata 0x12345678, HREADY low for 2 data-phase cycles -> HWDATA stable for 3 cycles, ls_rvalid at cycle 6, rdata unchanged.
REQ-045 The bench SHALL cover simultaneous requests: if_req and ls_req in the same cycle -> ls served first, if served next, with exactly one gnt per transfer.
REQ-046 The bench SHALL cover starvation: if_req held while ls_req is re-asserted continuously -> if_gnt after exactly 3 ls grants.
REQ-047 The bench SHALL cover reset mid-DATA: rst during a stalled fetch -> next cycle HTRANS=IDLE and all pulses 0, followed by normal completion after re-request.
